// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map, LFSR constants and STATUS bit positions for the data port
package mem_map_pkg;
  localparam logic [31:0] RNG_ADDR    = 32'h0000_1000;
  localparam logic [31:0] TIMER_ADDR  = 32'h0000_1004;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_1008;
  localparam logic [31:0] LED_ADDR    = 32'h0000_100C;
  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED   = 32'hACE1_0001;
  localparam int ST_DONE = 0;
  localparam int ST_ERR  = 1;
endpackage

// File: rtl/lfsr32.sv
// lfsr32: free-running Galois right-shift LFSR with seed load and zero lock-up guard
module lfsr32
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] q
);
  // load takes priority over the advance; a zero seed would lock the register up
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= LFSR_SEED;
    else q <= load ? (seed == 32'd0 ? 32'd1 : seed) : (q >> 1) ^ (q[0] ? LFSR_MASK : 32'd0);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: RAM, RNG, timer, STATUS and LED behind the single-cycle CPU data port
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int LED_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWrite,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] leds,
  output logic             timer_done
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] a, rng, count;
  logic is_ram, is_rng, is_tmr, is_st, is_led, done, err, set_done, set_err;
  assign a          = ALUResult & ~32'h3;
  assign is_ram     = a[31:AW+2] == '0;
  assign is_rng     = a == RNG_ADDR;
  assign is_tmr     = a == TIMER_ADDR;
  assign is_st      = a == STATUS_ADDR;
  assign is_led     = a == LED_ADDR;
  assign set_done   = count == 32'd1 && !(MemWrite && is_tmr);
  assign set_err    = MemWrite && !(is_ram || is_rng || is_tmr || is_st || is_led);
  assign timer_done = done;
  lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (MemWrite && is_rng),
    .seed (WriteData),
    .q    (rng)
  );
  // RAM write port; contents survive reset
  always_ff @(posedge clk)
    if (MemWrite && is_ram) ram[a[AW+1:2]] <= WriteData;
  // timer, sticky flags and LED register; sets beat same-cycle W1C clears
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      leds  <= '0;
    end else begin
      count <= (MemWrite && is_tmr) ? WriteData : (count != 32'd0 ? count - 32'd1 : count);
      done  <= set_done | (done & ~(MemWrite && is_st && WriteData[ST_DONE]));
      err   <= set_err | (err & ~(MemWrite && is_st && WriteData[ST_ERR]));
      if (MemWrite && is_led) leds <= WriteData[LED_W-1:0];
    end
  // zero-latency read mux
  always_comb
    ReadData = is_ram ? ram[a[AW+1:2]] :
               is_rng ? rng :
               is_tmr ? count :
               is_st  ? {30'd0, err, done} :
               is_led ? 32'(leds) : 32'd0;
endmodule
